// File: rtl/mmu_feeder.sv
// mmu_feeder: stages one tile for a SIZE x SIZE weight-stationary systolic array.
// Per tile: SIZE weight words are collected over a valid/ready handshake and
// replayed as a gap-free preload burst (control/wt_arr). After SETTLE idle cycles,
// num_vec activation vectors are streamed in. A zero-filled drain period then
// flushes the array, and done pulses.
// Optional feature macro MMU_FEEDER_SKEW_EN: lane k of each activation beat is
// delayed by k extra cycles (diagonal skew) and the drain lasts 2*SIZE-1 cycles.
// When the macro is undefined, all lanes leave together and the drain lasts SIZE cycles.
module mmu_feeder #(
  parameter int SIZE      = 4,
  parameter int BIT_WIDTH = 8,
  parameter int ARR_WIDTH = SIZE * BIT_WIDTH,
  parameter int SETTLE    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           num_vec,
  input  logic                 wt_valid,
  output logic                 wt_ready,
  input  logic [ARR_WIDTH-1:0] wt_in,
  input  logic                 act_valid,
  output logic                 act_ready,
  input  logic [ARR_WIDTH-1:0] act_in,
  output logic                 control,
  output logic [ARR_WIDTH-1:0] wt_arr,
  output logic [ARR_WIDTH-1:0] data_arr,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = 16;
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
`ifdef MMU_FEEDER_SKEW_EN
  localparam int DRAIN_LEN = 2 * SIZE - 1;
`else
  localparam int DRAIN_LEN = SIZE;
`endif

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_W   = 3'd1;
  localparam logic [2:0] EMIT_W   = 3'd2;
  localparam logic [2:0] SETTLE_S = 3'd3;
  localparam logic [2:0] STREAM   = 3'd4;
  localparam logic [2:0] DRAIN    = 3'd5;

  localparam logic [CNT_W-1:0] LAST_W = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LAST_D = CNT_W'(DRAIN_LEN - 1);

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CNT_W-1:0]     nv_last;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_inc;
  logic [7:0]           nv;
  logic [ARR_WIDTH-1:0] wbuf [SIZE];

  // One shared counter serves every phase; it is cleared on each state change.
  assign cnt_inc = cnt + CNT_W'(1);
  assign idx     = cnt[IDX_W-1:0];
  assign idx_inc = cnt_inc[IDX_W-1:0];
  assign nv_last = CNT_W'(nv) - CNT_W'(1);

  // Tile sequencer; every output is registered from the transition taken this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      nv        <= '0;
      wt_ready  <= 1'b0;
      act_ready <= 1'b0;
      control   <= 1'b0;
      wt_arr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < SIZE; i++) wbuf[i] <= '0;
    end else begin
      control <= 1'b0;
      wt_arr  <= '0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD_W;
            cnt      <= '0;
            nv       <= num_vec;
            wt_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD_W: begin
          if (wt_valid && wt_ready) begin
            wbuf[idx] <= wt_in;
            if (cnt == LAST_W) begin
              // Start the preload burst on the very next cycle; slot 0 is the
              // incoming word itself only when SIZE is 1.
              state    <= EMIT_W;
              cnt      <= '0;
              wt_ready <= 1'b0;
              control  <= 1'b1;
              wt_arr   <= (cnt == '0) ? wt_in : wbuf[0];
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        EMIT_W: begin
          if (cnt == LAST_W) begin
            state <= SETTLE_S;
            cnt   <= '0;
          end else begin
            cnt     <= cnt_inc;
            control <= 1'b1;
            wt_arr  <= wbuf[idx_inc];
          end
        end
        SETTLE_S: begin
          if (cnt == LAST_S) begin
            cnt <= '0;
            if (nv == 8'd0) begin
              state <= DRAIN;
            end else begin
              state     <= STREAM;
              act_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        STREAM: begin
          if (act_valid && act_ready) begin
            if (cnt == nv_last) begin
              state     <= DRAIN;
              cnt       <= '0;
              act_ready <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        DRAIN: begin
          if (cnt == LAST_D) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          wt_ready  <= 1'b0;
          act_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  logic                 vld_p0;
  logic [ARR_WIDTH-1:0] act_p0;

  // Stage p0: capture accepted activation beats; non-accept cycles feed zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      act_p0 <= '0;
    end else begin
      vld_p0 <= act_valid && act_ready;
      act_p0 <= act_in;
    end
  end

  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    logic [BIT_WIDTH-1:0] lane_p0;
    logic [BIT_WIDTH-1:0] lane_q;

    assign lane_p0 = vld_p0 ? act_p0[k*BIT_WIDTH +: BIT_WIDTH] : '0;
    assign data_arr[k*BIT_WIDTH +: BIT_WIDTH] = lane_q;

`ifdef MMU_FEEDER_SKEW_EN
    if (k == 0) begin : g_direct
      // Stage p1: lane 0 has no skew delay.
      always_ff @(posedge clk) begin
        if (rst) lane_q <= '0;
        else     lane_q <= lane_p0;
      end
    end else begin : g_skew
      logic [BIT_WIDTH-1:0] dly_p1 [k];

      // Stages p1..pk: lane k passes through k extra registers before the output.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < k; i++) dly_p1[i] <= '0;
          lane_q <= '0;
        end else begin
          dly_p1[0] <= lane_p0;
          for (int i = 1; i < k; i++) dly_p1[i] <= dly_p1[i-1];
          lane_q <= dly_p1[k-1];
        end
      end
    end
`else
    // Stage p1: all lanes leave together one cycle after acceptance.
    always_ff @(posedge clk) begin
      if (rst) lane_q <= '0;
      else     lane_q <= lane_p0;
    end
`endif
  end

endmodule

// File: tb/tb_mmu_feeder.sv
// Directed testbench for mmu_feeder (SIZE=4, BIT_WIDTH=8, SETTLE=8).
// Expectations follow MMU_FEEDER_SKEW_EN in the same way as the design build.
module tb_mmu_feeder;

`ifdef MMU_FEEDER_SKEW_EN
  localparam int SKEW = 1;
  localparam int DLEN = 7;
`else
  localparam int SKEW = 0;
  localparam int DLEN = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_vec;
  logic        wt_valid;
  logic        wt_ready;
  logic [31:0] wt_in;
  logic        act_valid;
  logic        act_ready;
  logic [31:0] act_in;
  logic        control;
  logic [31:0] wt_arr;
  logic [31:0] data_arr;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  int          n_acc;
  int          acc_cyc [8];
  logic [31:0] acc_val [8];

  mmu_feeder dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_in(wt_in),
    .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in),
    .control(control), .wt_arr(wt_arr), .data_arr(data_arr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected data_arr after edge cyc, from the accepted beats recorded so far.
  function automatic logic [31:0] exp_data(input int cyc);
    logic [31:0] r;
    int d;
    r = '0;
    for (int i = 0; i < n_acc; i++)
      for (int k = 0; k < 4; k++) begin
        d = (SKEW != 0) ? k + 1 : 1;
        if (cyc == acc_cyc[i] + d) r[k*8 +: 8] = acc_val[i][k*8 +: 8];
      end
    return r;
  endfunction

  // Start a tile, load four weight words back to back, wait for act_ready.
  task automatic run_to_stream(input logic [7:0] nv);
    int got;
    int guard;
    start = 1'b1; num_vec = nv;
    step();
    start = 1'b0;
    got = 0; guard = 0;
    while (got < 4 && guard < 20) begin
      wt_valid = 1'b1;
      wt_in = 32'h11111111 * (got + 1);
      if (wt_ready) got++;
      step();
      guard++;
    end
    wt_valid = 1'b0;
    guard = 0;
    while (!act_ready && guard < 30) begin
      step();
      guard++;
    end
    n_assert++;
    if (act_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_entry: act_ready got %b want 1", act_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_vec = 8'd0; wt_valid = 1'b0; wt_in = '0;
    act_valid = 1'b0; act_in = '0;
    step();
    step();
    n_assert++; if (control !== 1'b0) begin n_fail++; $display("FAIL rst_control: got %b want 0", control); end
    n_assert++; if (wt_arr !== 32'h0) begin n_fail++; $display("FAIL rst_wt_arr: got %h want 0", wt_arr); end
    n_assert++; if (data_arr !== 32'h0) begin n_fail++; $display("FAIL rst_data_arr: got %h want 0", data_arr); end
    n_assert++; if (wt_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wt_ready: got %b want 0", wt_ready); end
    n_assert++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL rst_act_ready: got %b want 0", act_ready); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    rst = 1'b0;
    step();
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_weight_load();
    logic [31:0] w [4];
    logic        pat [6];
    int          wi;
    int          guard;
    w[0] = 32'h01020304; w[1] = 32'h05060708; w[2] = 32'h090A0B0C; w[3] = 32'h0D0E0F10;
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b0; pat[4] = 1'b1; pat[5] = 1'b1;
    start = 1'b1; num_vec = 8'd1;
    step();
    start = 1'b0;
    n_assert++; if (wt_ready !== 1'b1) begin n_fail++; $display("FAIL load_wt_ready: got %b want 1", wt_ready); end
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b want 1", busy); end
    wi = 0;
    for (int i = 0; i < 6; i++) begin
      wt_valid = pat[i];
      wt_in = pat[i] ? w[wi] : 32'hDEADBEEF;
      if (pat[i]) wi++;
      step();
      if (i < 5) begin
        n_assert++; if (control !== 1'b0) begin n_fail++; $display("FAIL load_control_early: got %b want 0 (beat %0d)", control, i); end
      end
    end
    wt_valid = 1'b0;
    n_assert++; if (wt_ready !== 1'b0) begin n_fail++; $display("FAIL load_wt_ready_drop: got %b want 0", wt_ready); end
    for (int j = 0; j < 4; j++) begin
      n_assert++; if (control !== 1'b1) begin n_fail++; $display("FAIL emit_control_%0d: got %b want 1", j, control); end
      n_assert++; if (wt_arr !== w[j]) begin n_fail++; $display("FAIL emit_word_%0d: got %h want %h", j, wt_arr, w[j]); end
      step();
    end
    n_assert++; if (control !== 1'b0) begin n_fail++; $display("FAIL emit_end_control: got %b want 0", control); end
    n_assert++; if (wt_arr !== 32'h0) begin n_fail++; $display("FAIL emit_end_wt_arr: got %h want 0", wt_arr); end
    for (int s = 0; s < 7; s++) step();
    n_assert++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL settle_last_ready: got %b want 0", act_ready); end
    step();
    n_assert++; if (act_ready !== 1'b1) begin n_fail++; $display("FAIL settle_exit_ready: got %b want 1", act_ready); end
    act_valid = 1'b1; act_in = 32'h01010101;
    step();
    act_valid = 1'b0;
    n_assert++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL single_beat_ready: got %b want 0", act_ready); end
    guard = 0;
    while (!done && guard < 20) begin step(); guard++; end
    n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL load_tile_done: got %b want 1", done); end
    step();
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_skew();
    run_to_stream(8'd1);
    n_acc = 0;
    act_valid = 1'b1; act_in = 32'h44332211;
    acc_cyc[0] = 1; acc_val[0] = 32'h44332211; n_acc = 1;
    step();
    act_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      n_assert++; if (data_arr !== exp_data(c)) begin n_fail++; $display("FAIL skew_data_c%0d: got %h want %h", c, data_arr, exp_data(c)); end
      n_assert++; if (done !== (c == 1 + DLEN)) begin n_fail++; $display("FAIL skew_done_c%0d: got %b want %b", c, done, (c == 1 + DLEN)); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    run_to_stream(8'd3);
    n_acc = 0;
    for (int c = 0; c < 16; c++) begin
      act_valid = (c % 2 == 0);
      act_in = 32'h04030201 * (c + 1);
      if (act_valid && act_ready && n_acc < 8) begin
        acc_cyc[n_acc] = c + 1; acc_val[n_acc] = act_in; n_acc++;
      end
      step();
      exp_done = (n_acc == 3) && (c + 1 == acc_cyc[2] + DLEN);
      n_assert++; if (data_arr !== exp_data(c + 1)) begin n_fail++; $display("FAIL bp_data_c%0d: got %h want %h", c + 1, data_arr, exp_data(c + 1)); end
      n_assert++; if (act_ready !== (n_acc < 3)) begin n_fail++; $display("FAIL bp_ready_c%0d: got %b want %b", c + 1, act_ready, (n_acc < 3)); end
      n_assert++; if (done !== exp_done) begin n_fail++; $display("FAIL bp_done_c%0d: got %b want %b", c + 1, done, exp_done); end
    end
    act_valid = 1'b0;
    n_assert++; if (n_acc != 3) begin n_fail++; $display("FAIL bp_beats: got %0d want 3", n_acc); end
  endtask

  task automatic test_zero_vec();
    start = 1'b1; num_vec = 8'd0; wt_valid = 1'b1; wt_in = 32'h5A5A5A5A;
    step();
    start = 1'b0;
    for (int e = 0; e <= 16 + DLEN + 2; e++) begin
      n_assert++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL zv_act_ready_e%0d: got %b want 0", e, act_ready); end
      n_assert++; if (data_arr !== 32'h0) begin n_fail++; $display("FAIL zv_data_e%0d: got %h want 0", e, data_arr); end
      n_assert++; if (wt_ready !== (e < 4)) begin n_fail++; $display("FAIL zv_wt_ready_e%0d: got %b want %b", e, wt_ready, (e < 4)); end
      n_assert++; if (control !== (e >= 4 && e < 8)) begin n_fail++; $display("FAIL zv_control_e%0d: got %b want %b", e, control, (e >= 4 && e < 8)); end
      n_assert++; if (done !== (e == 16 + DLEN)) begin n_fail++; $display("FAIL zv_done_e%0d: got %b want %b", e, done, (e == 16 + DLEN)); end
      n_assert++; if (busy !== (e < 16 + DLEN)) begin n_fail++; $display("FAIL zv_busy_e%0d: got %b want %b", e, busy, (e < 16 + DLEN)); end
      step();
    end
    wt_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_to_stream(8'd2);
    act_valid = 1'b1; act_in = 32'h44332211;
    step();
    act_valid = 1'b0;
    n_assert++; if (act_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_before_rst: got %b want 1", act_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_assert++; if (control !== 1'b0) begin n_fail++; $display("FAIL mid_control: got %b want 0", control); end
    n_assert++; if (wt_arr !== 32'h0) begin n_fail++; $display("FAIL mid_wt_arr: got %h want 0", wt_arr); end
    n_assert++; if (data_arr !== 32'h0) begin n_fail++; $display("FAIL mid_data_arr: got %h want 0", data_arr); end
    n_assert++; if (wt_ready !== 1'b0) begin n_fail++; $display("FAIL mid_wt_ready: got %b want 0", wt_ready); end
    n_assert++; if (act_ready !== 1'b0) begin n_fail++; $display("FAIL mid_act_ready: got %b want 0", act_ready); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", done); end
    for (int c = 0; c < 4; c++) begin
      step();
      n_assert++; if (data_arr !== 32'h0) begin n_fail++; $display("FAIL mid_flush_c%0d: got %h want 0", c, data_arr); end
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_c%0d: got %b want 0", c, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_skew();
    test_back_to_back();
    test_zero_vec();
    test_reset_mid();
    test_skew();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_feeder.md
MMU_FEEDER -- requirements
Module: mmu_feeder

Interface
REQ-001 The block SHALL take parameter SIZE, default 4: systolic array dimension (lanes per vector).
REQ-002 The block SHALL take parameter BIT_WIDTH, default 8: bits per lane element.
REQ-003 The block SHALL take parameter ARR_WIDTH, default 32 (SIZE*BIT_WIDTH): vector width.
REQ-004 The block SHALL take parameter SETTLE, default 8: idle cycles between the last weight word and the first activation beat.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1, tile start request, sampled in IDLE only.
REQ-008 The block SHALL have port num_vec, input, 8, activation vectors in this tile, latched when start is accepted.
REQ-009 The block SHALL have ports wt_valid (input, 1), wt_ready (output, 1) and wt_in (input, ARR_WIDTH), the weight-word handshake.
REQ-010 The block SHALL have ports act_valid (input, 1), act_ready (output, 1) and act_in (input, ARR_WIDTH), the activation handshake; lane k = act_in[k*BIT_WIDTH +: BIT_WIDTH].
REQ-011 The block SHALL have ports control (output, 1) and wt_arr (output, ARR_WIDTH), the weight-preload strobe and word to the array.
REQ-012 The block SHALL have port data_arr, output, ARR_WIDTH, skewed activation vector to the array.
REQ-013 The block SHALL have ports busy (output, 1), high outside IDLE, and done (output, 1), a one-cycle pulse at tile end.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD_W, EMIT_W, SETTLE_S, STREAM, DRAIN.
REQ-015 IDLE SHALL go to LOAD_W when start=1, latching num_vec and clearing counters.
REQ-016 LOAD_W SHALL hold wt_ready=1, store each accepted word (wt_valid&wt_ready) into buffer slot 0..SIZE-1 in arrival order, and go to EMIT_W after the SIZE-th beat; gaps in wt_valid SHALL be tolerated.
REQ-017 EMIT_W SHALL drive control=1 and wt_arr=slot j on SIZE consecutive cycles, j=0..SIZE-1, with no gaps, then go to SETTLE_S.
REQ-018 In all other cycles control SHALL be 0 and wt_arr SHALL be 0.
REQ-019 SETTLE_S SHALL last exactly SETTLE cycles, then go to STREAM, or to DRAIN if num_vec=0.
REQ-020 STREAM SHALL hold act_ready=1 while accepted count < num_vec, and go to DRAIN in the cycle the num_vec-th beat is accepted.
REQ-021 Skew: a beat accepted at edge t SHALL put lane k on data_arr lane k at edge t+1+k; lane k SHALL be 0 in cycles with no beat scheduled for it.
REQ-022 DRAIN SHALL last 2*SIZE-1 cycles, feeding zeros into the skew pipe, then pulse done=1 for one cycle and return to IDLE.
REQ-023 wt_ready SHALL be 0 outside LOAD_W, act_ready SHALL be 0 outside STREAM, and start SHALL be ignored while busy=1.
REQ-024 All outputs SHALL be registered; handshake-ready outputs SHALL depend on state and counters only, never combinationally on valid inputs.

Reset
REQ-025 rst=1 at any edge, including mid-tile, SHALL force IDLE, clear the weight buffer, skew pipe and counters, and drive control, wt_arr, data_arr, wt_ready, act_ready, busy and done to 0 on the next edge.

Configuration
REQ-026 With macro MMU_FEEDER_SKEW_EN defined, the block SHALL skew per REQ-021 and drain per REQ-022.
REQ-027 Without MMU_FEEDER_SKEW_EN, all lanes SHALL appear at t+1, DRAIN SHALL last SIZE cycles, and the skew registers SHALL be absent.

Verification
REQ-028 Weight load: start, num_vec=1; wt words 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 with a 2-cycle wt_valid gap -> control high exactly 4 consecutive cycles carrying these words in order.
REQ-029 Skew: act_in=0x44332211 accepted at edge t -> data_arr lane0=0x11 at t+1, lane1=0x22 at t+2, lane2=0x33 at t+3, lane3=0x44 at t+4, other lanes 0.
REQ-030 Backpressure and count: num_vec=3, act_valid toggling every cycle -> exactly 3 beats accepted, act_ready falls after the 3rd, done pulses 7 cycles after entering DRAIN.
REQ-031 num_vec=0 -> no act_ready assertion, and done follows SETTLE_S+DRAIN with data_arr=0 throughout.
REQ-032 rst asserted in the 2nd STREAM cycle -> all outputs 0 on the next edge, busy=0, and a following start runs a clean tile.
REQ-033 With MMU_FEEDER_SKEW_EN undefined, act_in=0x44332211 -> data_arr=0x44332211 at t+1, and DRAIN lasts 4 cycles.
